wb_skid_delay: RTL

- Parametrised successor to the single-register wishbone bus delay.
- Inserts one registered stage on the pipelined wishbone request path, with a one-entry skid buffer so o_wb_stall can be registered without losing throughput.
- Tracks outstanding requests against a configurable limit.
- Handles bus errors and cycle aborts cleanly, with byte selects.
- Sits between any bus master (CPU, DMA) and the interconnect to break long timing paths.

---
 rtl/wb_skid_delay.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_skid_delay.sv
// wb_skid_delay: one registered stage on the pipelined wishbone request path, with a one-entry skid buffer and an outstanding-request limit
// Ports: i_clk, i_reset (async, active-high); i_wb_* upstream request in, o_wb_* upstream response out;
//        o_dly_* delayed request out to the interconnect, i_dly_* downstream response in.
module wb_skid_delay #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LGDEPTH  = 4,
    parameter int OPT_SKID = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [DW-1:0]     i_wb_data,
    input  logic [DW/8-1:0]   i_wb_sel,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic              o_wb_err,
    output logic [DW-1:0]     o_wb_data,
    output logic              o_dly_cyc,
    output logic              o_dly_stb,
    output logic              o_dly_we,
    output logic [AW-1:0]     o_dly_addr,
    output logic [DW-1:0]     o_dly_data,
    output logic [DW/8-1:0]   o_dly_sel,
    input  logic              i_dly_ack,
    input  logic              i_dly_stall,
    input  logic              i_dly_err,
    input  logic [DW-1:0]     i_dly_data
);
    localparam int RW = 1 + AW + DW + DW / 8;
    localparam logic [LGDEPTH-1:0] MAX = '1;
    typedef enum logic [1:0] {IDLE, ACTIVE, ERRWAIT} state_t;
    state_t state, state_n;
    logic [LGDEPTH-1:0] cnt, cnt_n, cnt_d;
    logic [RW-1:0] up_req, out_req, skid_q;
    logic up_acc, dn_acc, dec, load, issue, flush, err_stall, skid_v;
    assign up_req = {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};
    assign {o_dly_we, o_dly_addr, o_dly_data, o_dly_sel} = out_req;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) state <= IDLE;
        else state <= state_n;
    always_comb
        state_n = !i_wb_cyc ? IDLE :
                  state == IDLE ? ACTIVE :
                  (state == ACTIVE && o_dly_cyc && i_dly_err) ? ERRWAIT : state;
    // Idle never stalls, so the first request of a cycle is taken on the edge where cyc rises;
    // only ERRWAIT holds the master off.
    always_comb begin
        flush     = state_n != ACTIVE;
        err_stall = OPT_SKID != 0 ? state_n == ERRWAIT : state == ERRWAIT;
    end
    assign up_acc = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign dn_acc = o_dly_stb && !i_dly_stall;
    assign dec    = (i_dly_ack || i_dly_err) && o_dly_cyc && cnt != '0;
    assign cnt_n  = cnt + LGDEPTH'(dn_acc) - LGDEPTH'(dec);
    assign cnt_d  = flush ? '0 : cnt_n;
    assign load   = !o_dly_stb || !i_dly_stall;
    // A new strobe is only raised if, after this edge's accept, one more request still fits.
    assign issue  = load && (skid_v || up_acc) && cnt_n != MAX && !flush;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            cnt       <= '0;
            o_dly_cyc <= 1'b0;
            o_dly_stb <= 1'b0;
            out_req   <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            cnt       <= cnt_d;
            o_dly_cyc <= state_n == ACTIVE && i_wb_cyc && !i_dly_err;
            o_dly_stb <= issue || (o_dly_stb && !load && !flush);
            if (issue) out_req <= skid_v ? skid_q : up_req;
            o_wb_ack  <= i_dly_ack && o_dly_cyc && i_wb_cyc && state == ACTIVE;
            o_wb_err  <= i_dly_err && o_dly_cyc && i_wb_cyc;
            o_wb_data <= i_dly_data;
        end
    if (OPT_SKID != 0) begin : g_skid
        logic skid_vn;
        // Registered stall means one request may still arrive after the output stage blocks; it lands here.
        assign skid_vn = (skid_v || up_acc) && !issue && !flush;
        always_ff @(posedge i_clk or posedge i_reset)
            if (i_reset) begin
                skid_v     <= 1'b0;
                skid_q     <= '0;
                o_wb_stall <= 1'b0;
            end else begin
                skid_v     <= skid_vn;
                if (up_acc && !skid_v) skid_q <= up_req;
                o_wb_stall <= skid_vn || cnt_d == MAX || err_stall;
            end
    end else begin : g_direct
        assign skid_v     = 1'b0;
        assign skid_q     = '0;
        assign o_wb_stall = (o_dly_stb && i_dly_stall) || cnt_n == MAX || err_stall;
    end
endmodule
